// File: rtl/cpu_pkg.sv
// Shared types and constants for the control sequencer and its decoder.
package cpu_pkg;

   // Opcode field instr[8:6]
   typedef enum logic [2:0] {
      OP_MOV  = 3'b000,
      OP_MOVI = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUBI = 3'b011,
      OP_LD   = 3'b100,
      OP_ST   = 3'b101,
      OP_LEA  = 3'b110,
      OP_BR   = 3'b111   // rb == 0 is HALT, otherwise BNZ
   } op_t;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   // ALU operation encodings driven on alu_op
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_PASS = 2'b11;

   // Constant the register file writes when lea is asserted
   localparam logic [7:0] ENTRY = 8'h10;

   // Decoded view of one instruction
   typedef struct packed {
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] imm;
      logic       mode;
      logic       lea;
      logic       reg_to_reg;
      logic [1:0] alu_op;
      logic       exec_write;  // retires in EXEC with a register write
      logic       is_mem;
      logic       is_st;
      logic       is_halt;
      logic       is_bnz;
   } ctrl_t;

   // Registered values of every control output for one cycle
   typedef struct packed {
      logic [2:0] reg_dest;
      logic [2:0] reg_src;
      logic [2:0] reg_write;
      logic [7:0] immediate;
      logic       mode;
      logic       lea;
      logic       reg_to_reg;
      logic       write_enable;
      logic       wb_mem;
      logic [1:0] alu_op;
      logic       mem_req;
      logic       mem_we;
      logic       done;
   } out_t;

   // Zero-extend the 3-bit immediate field to data width
   function automatic logic [7:0] zext3(input logic [2:0] v);
      return {5'b00000, v};
   endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction decoder: IR -> control-line bundle.
module insn_decode
   import cpu_pkg::*;
(
   input  logic [8:0] ir,
   output ctrl_t      ctrl
);

   op_t op;
   assign op = op_t'(ir[8:6]);

   // Decode opcode and operand fields into control lines
   always_comb begin
      ctrl     = '0;
      ctrl.ra  = ir[5:3];
      ctrl.rb  = ir[2:0];
      ctrl.imm = zext3(ir[2:0]);
      case (op)
         OP_MOV: begin
            ctrl.reg_to_reg = 1'b1;
            ctrl.alu_op     = ALU_PASS;
            ctrl.exec_write = 1'b1;
         end
         OP_MOVI: begin
            ctrl.mode       = 1'b1;
            ctrl.alu_op     = ALU_PASS;
            ctrl.exec_write = 1'b1;
         end
         OP_ADD: begin
            ctrl.alu_op     = ALU_ADD;
            ctrl.exec_write = 1'b1;
         end
         OP_SUBI: begin
            ctrl.mode       = 1'b1;
            ctrl.alu_op     = ALU_SUB;
            ctrl.exec_write = 1'b1;
         end
         OP_LD: begin
            ctrl.is_mem = 1'b1;
         end
         OP_ST: begin
            ctrl.is_mem = 1'b1;
            ctrl.is_st  = 1'b1;
         end
         OP_LEA: begin
            ctrl.lea        = 1'b1;
            ctrl.exec_write = 1'b1;
         end
         OP_BR: begin
            if (ir[2:0] == 3'b000) begin
               ctrl.is_halt = 1'b1;
            end else begin
               ctrl.is_bnz = 1'b1;
            end
         end
         default: begin
            ctrl.exec_write = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control FSM: fetch/decode, memory handshake with timeout, PC, branch and halt.
// Outputs are registered: the values for the coming cycle are computed from the next state.
module ctrl_sequencer
   import cpu_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int MEM_TOUT = 16
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [8:0]      instr,
   input  logic [7:0]      rd_val,
   input  logic            mem_ack,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      reg_dest,
   output logic [2:0]      reg_src,
   output logic [2:0]      reg_write,
   output logic [7:0]      immediate,
   output logic            mode,
   output logic            lea,
   output logic            regToReg,
   output logic            write_enable,
   output logic            wb_mem,
   output logic [1:0]      alu_op,
   output logic            mem_req,
   output logic            mem_we,
   output logic            done,
   output logic            err
);

   localparam int                CNT_W     = $clog2(MEM_TOUT) + 1;
   localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(MEM_TOUT - 1);

   state_t            state, state_next;
   logic [8:0]        ir, ir_next;
   logic [PC_W-1:0]   pc_next, pc_inc, pc_br;
   logic [CNT_W-1:0]  tout_cnt, cnt_next;
   logic              err_next;
   ctrl_t             dec;
   out_t              outs, outs_next;

   // Decode the instruction that will sit in IR next cycle (fresh fetch or held)
   always_comb begin
      if (state == S_FETCH) begin
         ir_next = instr;
      end else begin
         ir_next = ir;
      end
   end

   insn_decode u_decode (
      .ir   (ir_next),
      .ctrl (dec)
   );

   assign pc_inc = pc + PC_W'(1);
   assign pc_br  = pc + {{(PC_W-3){dec.rb[2]}}, dec.rb};

   // Next-state, PC, timeout counter and sticky error
   always_comb begin
      state_next = state;
      pc_next    = pc;
      cnt_next   = tout_cnt;
      err_next   = err;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_next = S_FETCH;
               pc_next    = '0;
               err_next   = 1'b0;
            end else begin
               state_next = state;
            end
         end
         S_FETCH: begin
            state_next = S_EXEC;
         end
         S_EXEC: begin
            if (dec.is_mem) begin
               state_next = S_MEM;
               cnt_next   = '0;
            end else if (dec.is_halt) begin
               state_next = S_HALT;
            end else if (dec.is_bnz) begin
               state_next = S_FETCH;
               pc_next    = (rd_val != 8'h00) ? pc_br : pc_inc;
            end else begin
               state_next = S_FETCH;
               pc_next    = pc_inc;
            end
         end
         S_MEM: begin
            // An ack on the final allowed cycle still completes normally
            if (mem_ack) begin
               if (dec.is_st) begin
                  state_next = S_FETCH;
                  pc_next    = pc_inc;
               end else begin
                  state_next = S_WB;
               end
            end else if (tout_cnt == TOUT_LAST) begin
               state_next = S_HALT;
               err_next   = 1'b1;
            end else begin
               cnt_next = tout_cnt + CNT_W'(1);
            end
         end
         S_WB: begin
            state_next = S_FETCH;
            pc_next    = pc_inc;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output values for the cycle spent in the next state
   always_comb begin
      outs_next = '0;
      case (state_next)
         S_EXEC: begin
            outs_next.reg_dest     = dec.ra;
            outs_next.reg_src      = dec.rb;
            outs_next.reg_write    = dec.ra;
            outs_next.immediate    = dec.imm;
            outs_next.mode         = dec.mode;
            outs_next.lea          = dec.lea;
            outs_next.reg_to_reg   = dec.reg_to_reg;
            outs_next.alu_op       = dec.alu_op;
            outs_next.write_enable = dec.exec_write;
         end
         S_MEM: begin
            outs_next.reg_dest = dec.ra;
            outs_next.reg_src  = dec.rb;
            outs_next.mem_req  = 1'b1;
            outs_next.mem_we   = dec.is_st;
         end
         S_WB: begin
            outs_next.reg_dest     = dec.ra;
            outs_next.reg_src      = dec.rb;
            outs_next.reg_write    = dec.ra;
            outs_next.write_enable = 1'b1;
            outs_next.wb_mem       = 1'b1;
         end
         S_HALT: begin
            outs_next.done = 1'b1;
         end
         default: begin
            outs_next = '0;
         end
      endcase
   end

   // State, IR, PC, counter, error and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         ir       <= 9'h000;
         pc       <= '0;
         tout_cnt <= '0;
         err      <= 1'b0;
         outs     <= '0;
      end else begin
         state    <= state_next;
         ir       <= ir_next;
         pc       <= pc_next;
         tout_cnt <= cnt_next;
         err      <= err_next;
         outs     <= outs_next;
      end
   end

   assign reg_dest     = outs.reg_dest;
   assign reg_src      = outs.reg_src;
   assign reg_write    = outs.reg_write;
   assign immediate    = outs.immediate;
   assign mode         = outs.mode;
   assign lea          = outs.lea;
   assign regToReg     = outs.reg_to_reg;
   assign write_enable = outs.write_enable;
   assign wb_mem       = outs.wb_mem;
   assign alu_op       = outs.alu_op;
   assign mem_req      = outs.mem_req;
   assign mem_we       = outs.mem_we;
   assign done         = outs.done;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, mem_ack;
   logic [8:0] instr;
   logic [7:0] rd_val;
   logic [7:0] pc;
   logic [2:0] reg_dest, reg_src, reg_write;
   logic [7:0] immediate;
   logic       mode, lea, regToReg, write_enable, wb_mem;
   logic [1:0] alu_op;
   logic       mem_req, mem_we, done, err;

   logic [8:0] imem [256];
   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign instr = imem[pc];

   ctrl_sequencer #(.PC_W(8), .MEM_TOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .rd_val(rd_val),
      .mem_ack(mem_ack), .pc(pc), .reg_dest(reg_dest), .reg_src(reg_src),
      .reg_write(reg_write), .immediate(immediate), .mode(mode), .lea(lea),
      .regToReg(regToReg), .write_enable(write_enable), .wb_mem(wb_mem),
      .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int hi;
      int we_cnt;
      for (int i = 0; i < 256; i++) imem[i] = 9'b001_000_000;   // MOVI r0,0 filler
      imem[0] = 9'b001_001_101;   // MOVI r1,5
      imem[1] = 9'b100_010_011;   // LD r2,[r3]
      imem[2] = 9'b011_111_011;   // SUBI r7,3
      imem[5] = 9'b111_100_110;   // BNZ r4,-2
      imem[6] = 9'b101_001_010;   // ST [r2],r1
      reset = 1'b1; start = 1'b0; mem_ack = 1'b0; rd_val = 8'h00;
      steps(2);
      reset = 1'b0;
      step();
      chk("rst_pc", pc, 8'h00);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_we", write_enable, 1'b0);
      chk("rst_memreq", mem_req, 1'b0);
      chk("rst_regwrite", reg_write, 3'd0);
      chk("rst_imm", immediate, 8'h00);
      chk("rst_aluop", alu_op, 2'b00);

      // MOVI r1,5
      start = 1'b1; step(); start = 1'b0;
      chk("fetch_we", write_enable, 1'b0);
      step();
      chk("movi_mode", mode, 1'b1);
      chk("movi_imm", immediate, 8'h05);
      chk("movi_regwrite", reg_write, 3'd1);
      chk("movi_we", write_enable, 1'b1);
      chk("movi_pc_exec", pc, 8'h00);
      step();
      chk("movi_we_pulse", write_enable, 1'b0);
      chk("movi_pc", pc, 8'h01);

      // LD r2,[r3], ack on third MEM cycle
      step();
      chk("ld_exec_we", write_enable, 1'b0);
      chk("ld_exec_req", mem_req, 1'b0);
      step();
      chk("ld_req1", mem_req, 1'b1);
      chk("ld_we0", mem_we, 1'b0);
      chk("ld_src", reg_src, 3'd3);
      step();
      chk("ld_req2", mem_req, 1'b1);
      chk("ld_mem_we_strobe", write_enable, 1'b0);
      step();
      chk("ld_req3", mem_req, 1'b1);
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      chk("wb_req", mem_req, 1'b0);
      chk("wb_we", write_enable, 1'b1);
      chk("wb_mem", wb_mem, 1'b1);
      chk("wb_regwrite", reg_write, 3'd2);
      step();
      chk("ld_pc", pc, 8'h02);
      chk("ld_we_pulse", write_enable, 1'b0);

      // SUBI r7,3
      step();
      chk("subi_mode", mode, 1'b1);
      chk("subi_aluop", alu_op, 2'b01);
      chk("subi_imm", immediate, 8'h03);
      chk("subi_regwrite", reg_write, 3'd7);
      step();
      chk("subi_pc", pc, 8'h03);

      // BNZ r4,-2 at pc=5: taken then not taken
      steps(4);
      chk("pc_before_bnz", pc, 8'h05);
      rd_val = 8'h01;
      step();
      chk("bnz_we", write_enable, 1'b0);
      step();
      chk("bnz_taken_pc", pc, 8'h03);
      steps(4);
      rd_val = 8'h00;
      steps(2);
      chk("bnz_fall_pc", pc, 8'h06);

      // ST never acked: timeout into HALT with err
      step();
      step();
      chk("st_we1", mem_we, 1'b1);
      hi = 0;
      while (mem_req === 1'b1 && hi < 40) begin
         hi++;
         step();
      end
      chk("st_tout_len", hi, 16);
      chk("tout_err", err, 1'b1);
      chk("tout_done", done, 1'b1);
      chk("tout_pc", pc, 8'h06);
      step();
      chk("halt_pc_frozen", pc, 8'h06);
      chk("halt_err_sticky", err, 1'b1);

      // Restart; BNZ r4,-1 at pc=0 wraps to 0xFF
      imem[0] = 9'b111_100_111;
      rd_val  = 8'h01;
      start = 1'b1; step(); start = 1'b0;
      chk("restart_err", err, 1'b0);
      chk("restart_done", done, 1'b0);
      chk("restart_pc", pc, 8'h00);
      steps(2);
      chk("bnz_wrap_pc", pc, 8'hFF);

      // LD at 0xFF; start ignored in EXEC; reset mid-MEM
      imem[255] = 9'b100_000_000;
      step();
      start = 1'b1; step(); start = 1'b0;
      chk("start_ign_req", mem_req, 1'b1);
      chk("start_ign_pc", pc, 8'hFF);
      reset = 1'b1; step(); reset = 1'b0;
      chk("midmem_rst_req", mem_req, 1'b0);
      chk("midmem_rst_pc", pc, 8'h00);
      chk("midmem_rst_done", done, 1'b0);
      step();
      chk("idle_hold_req", mem_req, 1'b0);
      chk("idle_hold_pc", pc, 8'h00);

      // Program MOV r1,r2 / LEA r3 / ADD r4,r5 / HALT
      imem[0] = 9'b000_001_010;
      imem[1] = 9'b110_011_000;
      imem[2] = 9'b010_100_101;
      imem[3] = 9'b111_000_000;
      start = 1'b1; step(); start = 1'b0;
      step();
      chk("mov_we", write_enable, 1'b1);
      chk("mov_r2r", regToReg, 1'b1);
      chk("mov_regwrite", reg_write, 3'd1);
      step();
      chk("mov_gap_we", write_enable, 1'b0);
      step();
      chk("lea_we", write_enable, 1'b1);
      chk("lea_lea", lea, 1'b1);
      chk("lea_regwrite", reg_write, 3'd3);
      step();
      chk("lea_gap_we", write_enable, 1'b0);
      step();
      chk("add_we", write_enable, 1'b1);
      chk("add_regwrite", reg_write, 3'd4);
      chk("add_aluop", alu_op, 2'b00);
      chk("add_mode", mode, 1'b0);
      step();
      chk("pc_at_halt", pc, 8'h03);
      step();
      chk("halt_exec_we", write_enable, 1'b0);
      we_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (write_enable === 1'b1) we_cnt++;
      end
      chk("halt_no_we", we_cnt, 0);
      chk("halt_done", done, 1'b1);
      chk("halt_pc", pc, 8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
